// File: rtl/percept_cmd_tx.sv
// Serial command transmitter for the perceptron control line.
// FIFO-buffered (addr, op) commands go out as idle-high frames with a guard gap.
module percept_cmd_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [2:0]  cmd_op,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int GAP_E = (GAP < 2) ? 2 : GAP;
  localparam int GW    = $clog2(GAP_E) + 1;
  localparam logic [GW-1:0] GUARD_INIT = GW'(GAP_E - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GUARD
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [11:0]     sr_q, sr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [15:0]     frames_q, frames_d;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [10:0]     head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign push  = cmd_valid && !full;

  assign cmd_ready   = !full;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    guard_d  = guard_q;
    tx_d     = tx_q;
    frames_d = frames_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sr_d    = {head[10:3], 1'b1, head[2:0]};
          tx_d    = 1'b0;
          cnt_d   = 4'd11;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        tx_d = sr_q[11];
        sr_d = {sr_q[10:0], 1'b0};
        if (cnt_q == 4'd0) begin
          state_d  = S_GUARD;
          guard_d  = GUARD_INIT;
          frames_d = frames_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GUARD: begin
        tx_d = 1'b1;
        if (guard_q == '0) begin
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    busy_d = (state_q != S_IDLE) || !empty;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      guard_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      guard_q  <= guard_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      frames_q <= frames_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {cmd_addr, cmd_op};
    end
  end

endmodule

// File: tb/tb_percept_cmd_tx.sv
// Directed bench for percept_cmd_tx: frame bits, spacing, FIFO,
// reset abort and a loopback frame decoder standing in for a receiver.
module tb_percept_cmd_tx;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        v_main = 1'b0;
  logic        v_aux = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [2:0]  cmd_op = '0;
  logic        cmd_ready, tx, busy;
  logic [15:0] frames_sent;
  logic        rdy_g0, tx_g0, busy_g0;
  logic [15:0] fs_g0;
  logic        rdy_g2, tx_g2, busy_g2;
  logic [15:0] fs_g2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  percept_cmd_tx #(.FIFO_DEPTH(4), .GAP(4)) u_dut (
    .clk(clk), .nRst(nRst), .cmd_valid(v_main), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_op(cmd_op), .tx(tx), .busy(busy),
    .frames_sent(frames_sent)
  );

  percept_cmd_tx #(.FIFO_DEPTH(4), .GAP(0)) u_g0 (
    .clk(clk), .nRst(nRst), .cmd_valid(v_aux), .cmd_ready(rdy_g0),
    .cmd_addr(cmd_addr), .cmd_op(cmd_op), .tx(tx_g0), .busy(busy_g0),
    .frames_sent(fs_g0)
  );

  percept_cmd_tx #(.FIFO_DEPTH(4), .GAP(2)) u_g2 (
    .clk(clk), .nRst(nRst), .cmd_valid(v_aux), .cmd_ready(rdy_g2),
    .cmd_addr(cmd_addr), .cmd_op(cmd_op), .tx(tx_g2), .busy(busy_g2),
    .frames_sent(fs_g2)
  );

  // Receiver model on the main line: start bit, 8 addr, pad, 3 op.
  logic        dact;
  logic [3:0]  dcnt;
  logic [11:0] dsr;
  logic [2:0]  rx_op;
  int          pad_err;
  logic [10:0] rxq [$];

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dact    <= 1'b0;
      dcnt    <= '0;
      dsr     <= '0;
      rx_op   <= 3'd7;
    end else if (!dact) begin
      if (!tx) begin
        dact <= 1'b1;
        dcnt <= '0;
      end
    end else begin
      dsr <= {dsr[10:0], tx};
      if (dcnt == 4'd11) begin
        dact <= 1'b0;
        rxq.push_back({dsr[10:3], dsr[1:0], tx});
        if (dsr[2] !== 1'b1) pad_err <= pad_err + 1;
        if (dsr[10:3] == 8'h3C) rx_op <= {dsr[1:0], tx};
      end else begin
        dcnt <= dcnt + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic txs(input int sel);
    return (sel == 1) ? tx_g0 : (sel == 2) ? tx_g2 : tx;
  endfunction

  task automatic wait_start(input int sel, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (txs(sel) == 1'b0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("start_timeout", 32'd1, 32'd0);
  endtask

  task automatic meas(input int sel, input int nfr, input int exp,
                      input string tag);
    int t1, t2;
    wait_start(sel, t1);
    for (int f = 1; f < nfr; f++) begin
      repeat (13) @(posedge clk);
      wait_start(sel, t2);
      check(tag, 32'(t2 - t1), 32'(exp));
      t1 = t2;
    end
  endtask

  task automatic push1(input logic [7:0] a, input logic [2:0] o);
    @(negedge clk);
    cmd_addr = a;
    cmd_op   = o;
    v_main   = 1'b1;
    @(posedge clk); #1;
    v_main   = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    if (k >= 2000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  logic [7:0]  ba [4] = '{8'h01, 8'h02, 8'h03, 8'hFF};
  logic [2:0]  bo [4] = '{3'd0, 3'd3, 3'd6, 3'd7};
  logic [12:0] exp1 = 13'b0_10100101_1_101;
  logic [10:0] acc [$];

  initial begin
    int f0;
    int guard;
    logic r;
    logic saw_full;
    logic [7:0] na;
    pad_err = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frames", frames_sent, 0);
    @(negedge clk) nRst = 1'b1;

    // Single command 0xA5 / MUL
    push1(8'hA5, 3'd5);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      check($sformatf("single_bit%0d", k), tx, exp1[13-k]);
      if (k == 12) check("single_frames_pre", frames_sent, 0);
    end
    @(posedge clk); #1;
    check("single_tx_high", tx, 1);
    check("single_frames", frames_sent, 1);
    repeat (3) @(posedge clk);
    #1;
    check("single_busy_e17", busy, 1);
    @(posedge clk); #1;
    check("single_busy_e18", busy, 0);
    check("single_rx_n", rxq.size(), 1);
    if (rxq.size() > 0) check("single_rx", rxq[0], {8'hA5, 3'd5});

    // Back-to-back four commands
    rxq.delete();
    f0 = frames_sent;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          cmd_addr = ba[i];
          cmd_op   = bo[i];
          v_main   = 1'b1;
          check($sformatf("b2b_ready%0d", i), cmd_ready, 1);
        end
        @(negedge clk) v_main = 1'b0;
      end
      meas(0, 4, 17, "b2b_space");
    join
    wait_idle();
    check("b2b_frames", 32'(frames_sent - f0), 4);
    check("b2b_rx_n", rxq.size(), 4);
    for (int i = 0; i < 4 && i < rxq.size(); i++)
      check($sformatf("b2b_rx%0d", i), rxq[i], {ba[i], bo[i]});

    // Continuous valid against a full FIFO
    rxq.delete();
    acc.delete();
    saw_full = 1'b0;
    na = 8'h40;
    guard = 0;
    while (acc.size() < 10 && guard < 1000) begin
      @(negedge clk);
      cmd_addr = na;
      cmd_op   = na[2:0];
      v_main   = 1'b1;
      r = cmd_ready;
      @(posedge clk);
      if (r) begin
        acc.push_back({na, na[2:0]});
        na = na + 8'd1;
      end else begin
        saw_full = 1'b1;
      end
      guard++;
    end
    @(negedge clk) v_main = 1'b0;
    wait_idle();
    check("full_seen", saw_full, 1);
    check("full_acc_n", acc.size(), 10);
    check("full_rx_n", rxq.size(), acc.size());
    for (int i = 0; i < acc.size() && i < rxq.size(); i++)
      check($sformatf("full_rx%0d", i), rxq[i], acc[i]);

    // Reset during addr[3] of the first of two queued frames
    push1(8'h81, 3'd1);
    push1(8'h82, 3'd2);
    repeat (5) @(posedge clk);
    #2;
    check("mid_tx_low_bit", tx, 1'b0);
    nRst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_frames", frames_sent, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk) nRst = 1'b1;
    rxq.delete();
    repeat (5) @(posedge clk);
    #1;
    check("mid_post_busy", busy, 0);
    check("mid_post_tx", tx, 1);
    push1(8'h10, 3'd2);
    wait_idle();
    check("mid_new_n", rxq.size(), 1);
    if (rxq.size() > 0) check("mid_new_rx", rxq[0], {8'h10, 3'd2});
    check("mid_new_frames", frames_sent, 1);

    // Guard clamp: GAP=0 and GAP=2 both space starts by 15
    fork
      begin
        @(negedge clk);
        cmd_addr = 8'h55; cmd_op = 3'd1; v_aux = 1'b1;
        @(negedge clk);
        cmd_addr = 8'hAA; cmd_op = 3'd2;
        @(negedge clk) v_aux = 1'b0;
      end
      meas(1, 2, 15, "gap0_space");
      meas(2, 2, 15, "gap2_space");
    join
    repeat (20) @(posedge clk);
    #1;
    check("gap0_frames", fs_g0, 2);
    check("gap2_frames", fs_g2, 2);

    // Loopback into the receiver at 0x3C
    push1(8'h3C, 3'd4);
    wait_idle();
    check("loop_op1", rx_op, 3'd4);
    push1(8'h3D, 3'd6);
    wait_idle();
    check("loop_op2", rx_op, 3'd4);
    check("pad_bits", pad_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
